// File: rtl/dpram_fifo_sync_if.sv
// Stream/status bundle for dpram_fifo_sync; the producer/consumer side uses master, the FIFO uses slave.
interface dpram_fifo_sync_if #(
  parameter int aw = 4,
  parameter int dw = 8
);
  logic [dw-1:0] din;
  logic          we;
  logic          re;
  logic          clr_err;
  logic [dw-1:0] dout;
  logic          dout_valid;
  logic          full;
  logic          afull;
  logic          empty;
  logic          aempty;
  logic [aw:0]   count;
  logic          overflow;
  logic          underflow;

  modport master (
    output din, we, re, clr_err,
    input  dout, dout_valid, full, afull, empty, aempty, count, overflow, underflow
  );

  modport slave (
    input  din, we, re, clr_err,
    output dout, dout_valid, full, afull, empty, aempty, count, overflow, underflow
  );
endinterface

// File: rtl/dpram_fifo_sync.sv
// Single-clock FIFO on an inferred dual-port RAM; read latency 1 (DPRAM_FIFO_FWFT_EN: head word prefetched, 2-cycle fill).
// No backpressure: writes while full and reads while empty are dropped and flagged in sticky overflow/underflow.
module dpram_fifo_sync #(
  parameter int aw     = 4,
  parameter int dw     = 8,
  parameter int af_lvl = 2**aw - 2,
  parameter int ae_lvl = 2
) (
  input logic               clk,
  input logic               rst,
  dpram_fifo_sync_if.slave  bus
);
  localparam logic [aw:0] depth = (aw+1)'(2**aw);
  localparam logic [aw:0] af_th = (aw+1)'(af_lvl);
  localparam logic [aw:0] ae_th = (aw+1)'(ae_lvl);

  logic [dw-1:0] mem [2**aw];
  logic [aw-1:0] wr_ptr;
  logic [aw-1:0] rd_ptr;
  logic [aw:0]   count_nxt;
  logic          wr_ok;
  logic          pop;
  logic          ovf_evt;
  logic          udf_evt;

  assign wr_ok   = bus.we && !bus.full;
  assign ovf_evt = bus.we && bus.full;
  assign count_nxt = bus.count + (aw+1)'(wr_ok) - (aw+1)'(pop);

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[wr_ptr] <= bus.din;
  end

`ifdef DPRAM_FIFO_FWFT_EN
  logic [dw-1:0] pf_dat;
  logic          pf_vld;
  logic [aw:0]   mem_cnt;
  logic          out_free;
  logic          fetch;

  assign pop      = bus.re && bus.dout_valid;
  assign udf_evt  = bus.re && !bus.dout_valid;
  assign out_free = !bus.dout_valid || pop;
  // Words still sitting in the RAM: total occupancy minus the two staging registers.
  assign mem_cnt  = bus.count - (aw+1)'(bus.dout_valid) - (aw+1)'(pf_vld);
  assign fetch    = (mem_cnt != '0) && (!pf_vld || out_free);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr         <= '0;
      pf_dat         <= '0;
      pf_vld         <= 1'b0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
    end else begin
      if (out_free) begin
        bus.dout_valid <= pf_vld;
        if (pf_vld) bus.dout <= pf_dat;
      end
      if (fetch) begin
        pf_dat <= mem[rd_ptr];
        pf_vld <= 1'b1;
        rd_ptr <= rd_ptr + 1'b1;
      end else if (out_free) begin
        pf_vld <= 1'b0;
      end
    end
  end
`else
  assign pop     = bus.re && !bus.empty;
  assign udf_evt = bus.re && bus.empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr         <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
    end else begin
      bus.dout_valid <= pop;
      if (pop) begin
        bus.dout <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      bus.count     <= '0;
      bus.full      <= 1'b0;
      bus.afull     <= 1'b0;
      bus.empty     <= 1'b1;
      bus.aempty    <= 1'b1;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      bus.count  <= count_nxt;
      bus.full   <= (count_nxt == depth);
      bus.afull  <= (count_nxt >= af_th);
      bus.empty  <= (count_nxt == '0);
      bus.aempty <= (count_nxt <= ae_th);
      // A new error wins over a simultaneous clear.
      if (ovf_evt)          bus.overflow <= 1'b1;
      else if (bus.clr_err) bus.overflow <= 1'b0;
      if (udf_evt)          bus.underflow <= 1'b1;
      else if (bus.clr_err) bus.underflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dpram_fifo_sync.sv
// Randomised bench for dpram_fifo_sync against a queue-based model; the FWFT build runs a directed fall-through sequence.
module tb_dpram_fifo_sync;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dpram_fifo_sync_if #(.aw(AW), .dw(DW)) bus ();

  dpram_fifo_sync #(.aw(AW), .dw(DW), .af_lvl(AF), .ae_lvl(AE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a plain queue plus the sticky flags and the last read word.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  logic          m_dv   = 1'b0;
  logic          m_ovf  = 1'b0;
  logic          m_udf  = 1'b0;

  task automatic model_edge(input logic w, input logic r, input logic [DW-1:0] d,
                            input logic c, input logic rs);
    bit was_full, was_empty;
    if (rs) begin
      q.delete();
      m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_dv = r && !was_empty;
      if (m_dv) m_dout = q.pop_front();
      if (w && !was_full) q.push_back(d);
      if (w && was_full) m_ovf = 1'b1;
      else if (c)        m_ovf = 1'b0;
      if (r && was_empty) m_udf = 1'b1;
      else if (c)         m_udf = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("count",     32'(bus.count),     32'(q.size()));
    chk("full",      32'(bus.full),      32'(q.size() == DEPTH));
    chk("afull",     32'(bus.afull),     32'(q.size() >= AF));
    chk("empty",     32'(bus.empty),     32'(q.size() == 0));
    chk("aempty",    32'(bus.aempty),    32'(q.size() <= AE));
    chk("dout_valid",32'(bus.dout_valid),32'(m_dv));
    chk("dout",      32'(bus.dout),      32'(m_dout));
    chk("overflow",  32'(bus.overflow),  32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_udf));
  endtask

  task automatic drv(input logic w, input logic r, input logic [DW-1:0] d,
                     input logic c, input logic rs);
    @(negedge clk);
    rst = rs; bus.we = w; bus.re = r; bus.din = d; bus.clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic w, input logic r, input logic [DW-1:0] d,
                      input logic c, input logic rs);
    drv(w, r, d, c, rs);
    model_edge(w, r, d, c, rs);
    compare_all();
  endtask

  initial begin
    bus.we = 1'b0; bus.re = 1'b0; bus.din = '0; bus.clr_err = 1'b0;
`ifndef DPRAM_FIFO_FWFT_EN
    step(0, 0, 8'h00, 0, 1);
    step(1, 1, 8'h3C, 0, 1);

    // Fill to full, then one extra write that must be dropped.
    for (int i = 1; i <= 16; i++) step(1, 0, DW'(i), 0, 0);
    chk("t1_full_after_16", 32'(bus.full), 32'd1);
    step(1, 0, 8'h11, 0, 0);
    chk("t1_overflow_set", 32'(bus.overflow), 32'd1);

    // Drain in order, then read once more from empty.
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 8'h00, 0, 0);
      chk("t2_dout_seq", 32'(bus.dout), 32'(i));
    end
    step(0, 1, 8'h00, 0, 0);
    chk("t2_underflow_set", 32'(bus.underflow), 32'd1);
    step(0, 0, 8'h00, 1, 0);

    // Steady state at 8 entries across pointer wrap.
    for (int i = 0; i < 8; i++) step(1, 0, DW'($urandom), 0, 0);
    for (int i = 0; i < 40; i++) step(1, 1, DW'($urandom), 0, 0);
    chk("t3_count_steady", 32'(bus.count), 32'd8);

    // Reset mid-stream discards data.
    for (int i = 0; i < 5; i++) step(1, 0, DW'($urandom), 0, 0);
    step(0, 0, 8'h00, 0, 1);
    step(1, 0, 8'hAA, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    chk("t5_dout_after_rst", 32'(bus.dout), 32'hAA);
    step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    chk("t5_clr_err", 32'(bus.underflow), 32'd0);

    // Random traffic: fill-biased then drain-biased, occasional clears and resets.
    for (int i = 0; i < 600; i++) begin
      logic w, r, c, rs;
      int bias;
      bias = ((i / 75) % 2 == 0) ? 75 : 30;
      w  = ($urandom_range(99) < bias);
      r  = ($urandom_range(99) < 100 - bias);
      c  = ($urandom_range(19) == 0);
      rs = ($urandom_range(199) == 0);
      step(w, r, DW'($urandom), c, rs);
    end
`else
    drv(0, 0, 8'h00, 0, 1);
    chk("fw_reset_dv", 32'(bus.dout_valid), 32'd0);
    chk("fw_reset_empty", 32'(bus.empty), 32'd1);
    drv(1, 0, 8'h55, 0, 0);
    chk("fw_count_1", 32'(bus.count), 32'd1);
    drv(0, 0, 8'h00, 0, 0);
    chk("fw_dv_lat1", 32'(bus.dout_valid), 32'd0);
    drv(0, 0, 8'h00, 0, 0);
    chk("fw_dv_lat2", 32'(bus.dout_valid), 32'd1);
    chk("fw_dout_55", 32'(bus.dout), 32'h55);
    drv(1, 0, 8'h66, 0, 0);
    chk("fw_count_2", 32'(bus.count), 32'd2);
    drv(0, 0, 8'h00, 0, 0);
    drv(0, 0, 8'h00, 0, 0);
    chk("fw_hold_55", 32'(bus.dout), 32'h55);
    drv(0, 1, 8'h00, 0, 0);
    chk("fw_pop_dout_66", 32'(bus.dout), 32'h66);
    chk("fw_pop_dv", 32'(bus.dout_valid), 32'd1);
    chk("fw_pop_count", 32'(bus.count), 32'd1);
    drv(0, 1, 8'h00, 0, 0);
    chk("fw_drain_dv", 32'(bus.dout_valid), 32'd0);
    chk("fw_drain_empty", 32'(bus.empty), 32'd1);
    drv(0, 1, 8'h00, 0, 0);
    chk("fw_underflow", 32'(bus.underflow), 32'd1);
    drv(0, 0, 8'h00, 1, 0);
    chk("fw_clr_err", 32'(bus.underflow), 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
